// File: rtl/dual_port_ram_be_init_if.sv
// Port bundle for dual_port_ram_be_init.
//   we/be/w_addr/d   : write request, byte-lane enables, address, data
//   re/r_addr        : read request and address
//   q/q_valid        : read data and one-cycle new-word flag
//   init_busy        : high while the zero-fill sequence owns the array
// master = requester side, slave = RAM side.
interface dual_port_ram_be_init_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] d;
    logic                  re;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  init_busy;

    modport master (
        output we, be, w_addr, d, re, r_addr,
        input  q, q_valid, init_busy
    );

    modport slave (
        input  we, be, w_addr, d, re, r_addr,
        output q, q_valid, init_busy
    );
endinterface

// File: rtl/dual_port_ram_be_init.sv
// Simple dual-port RAM (one write port, one read port, single clock) with
// per-byte write enables, selectable read-during-write behaviour, optional
// output register and a zero-fill sequencer that runs after reset.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of dual_port_ram_be_init_if (write/read ports,
//           q/q_valid read response, init_busy status)
// DATA_WIDTH must be a multiple of BYTE_WIDTH.
module dual_port_ram_be_init #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int BYTE_WIDTH    = 8,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input logic                     clk,
    input logic                     reset,
    dual_port_ram_be_init_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_q;
    logic                  s1_v;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // User requests are only honoured once the array has been cleared.
    assign wr_en = (state == READY) && bus.we;
    assign rd_en = (state == READY) && bus.re;

    // Clear sequencer: one word per cycle, leaves after the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (INIT_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                state <= READY;
            end
        end
    end

    assign bus.init_busy = (state == CLEAR);

    // Array write: either the clear word or the lane-masked user write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (bus.we) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (bus.be[i]) begin
                        mem[bus.w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                            bus.d[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Read word; in new-data mode the enabled lanes of a same-address
    // write are forwarded so the merged word is returned.
    always_comb begin
        rd_word = mem[bus.r_addr];
        if ((RDW_MODE != 0) && wr_en && (bus.w_addr == bus.r_addr)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                        bus.d[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: data holds between reads, valid pulses per read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= rd_en;
            if (rd_en) begin
                s1_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_v;

            // Reset clears both stages, so an in-flight read never emerges.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                    out_v <= 1'b0;
                end else begin
                    out_v <= s1_v;
                    if (s1_v) begin
                        out_q <= s1_q;
                    end
                end
            end

            assign bus.q       = out_q;
            assign bus.q_valid = out_v;
        end else begin : g_no_out_reg
            assign bus.q       = s1_q;
            assign bus.q_valid = s1_v;
        end
    endgenerate
endmodule

// File: tb/tb_dual_port_ram_be_init.sv
// Directed bench for dual_port_ram_be_init. Three instances share one
// stimulus stream:
//   dut_a : RDW old data, no output reg, zero-fill on reset
//   dut_b : RDW new data, output reg,    zero-fill on reset
//   dut_c : RDW new data, no output reg, no zero-fill
module tb_dual_port_ram_be_init;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic [1:0]    be = '0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] d = '0;
    logic          re = 1'b0;
    logic [AW-1:0] r_addr = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dual_port_ram_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) if_a ();
    dual_port_ram_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) if_b ();
    dual_port_ram_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) if_c ();

    assign if_a.we = we;  assign if_a.be = be;  assign if_a.w_addr = w_addr;
    assign if_a.d = d;    assign if_a.re = re;  assign if_a.r_addr = r_addr;
    assign if_b.we = we;  assign if_b.be = be;  assign if_b.w_addr = w_addr;
    assign if_b.d = d;    assign if_b.re = re;  assign if_b.r_addr = r_addr;
    assign if_c.we = we;  assign if_c.be = be;  assign if_c.w_addr = w_addr;
    assign if_c.d = d;    assign if_c.re = re;  assign if_c.r_addr = r_addr;

    dual_port_ram_be_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
        .RDW_MODE(0), .OUT_REG(0), .INIT_ON_RESET(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));

    dual_port_ram_be_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
        .RDW_MODE(1), .OUT_REG(1), .INIT_ON_RESET(1)
    ) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    dual_port_ram_be_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
        .RDW_MODE(1), .OUT_REG(0), .INIT_ON_RESET(0)
    ) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic seen_v;

        // Reset state
        tick; tick;
        chk("rst_a_busy", 32'(if_a.init_busy), 1);
        chk("rst_a_q", 32'(if_a.q), 0);
        chk("rst_a_v", 32'(if_a.q_valid), 0);
        chk("rst_b_busy", 32'(if_b.init_busy), 1);
        chk("rst_b_q", 32'(if_b.q), 0);
        chk("rst_c_busy", 32'(if_c.init_busy), 0);

        // Partial clear, then reset at counter 9 restarts the sequence
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        chk("mid_a_busy", 32'(if_a.init_busy), 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        // Requests during CLEAR must be ignored
        we = 1'b1; be = 2'b11; w_addr = 4'd9; d = 16'hDEAD;
        re = 1'b1; r_addr = 4'd9;
        n = 0;
        seen_v = 1'b0;
        while (if_a.init_busy && n < 100) begin
            tick;
            n++;
            seen_v = seen_v | if_a.q_valid | if_b.q_valid;
        end
        we = 1'b0; re = 1'b0;
        chk("clear_len_a", 32'(n), 16);
        chk("clear_b_done", 32'(if_b.init_busy), 0);
        chk("clear_no_valid", 32'(seen_v), 0);

        // Every address reads zero; A at latency 1, B at latency 2
        for (int i = 0; i <= 17; i++) begin
            re = (i < 16);
            r_addr = 4'(i);
            tick;
            if (i < 16) begin
                chk("zero_a_q", 32'(if_a.q), 0);
                chk("zero_a_v", 32'(if_a.q_valid), 1);
            end else begin
                chk("zero_a_v_end", 32'(if_a.q_valid), 0);
            end
            if (i >= 1 && i <= 16) begin
                chk("zero_b_q", 32'(if_b.q), 0);
                chk("zero_b_v", 32'(if_b.q_valid), 1);
            end else begin
                chk("zero_b_v_idle", 32'(if_b.q_valid), 0);
            end
        end

        // Byte-enable writes to addr 5, then a be=0 write that must not land
        we = 1'b1; be = 2'b11; w_addr = 4'd5; d = 16'hABCD; tick;
        be = 2'b10; d = 16'h12EE; tick;
        be = 2'b00; d = 16'hFFFF; tick;
        we = 1'b0;
        re = 1'b1; r_addr = 4'd5; tick;
        re = 1'b0;
        chk("be_a_q", 32'(if_a.q), 32'h12CD);
        chk("be_a_v", 32'(if_a.q_valid), 1);
        chk("be_c_q", 32'(if_c.q), 32'h12CD);
        chk("be_b_v_early", 32'(if_b.q_valid), 0);
        tick;
        chk("be_b_q", 32'(if_b.q), 32'h12CD);
        chk("be_b_v", 32'(if_b.q_valid), 1);
        chk("hold_a_q", 32'(if_a.q), 32'h12CD);
        chk("hold_a_v", 32'(if_a.q_valid), 0);

        // Three back-to-back reads
        we = 1'b1; be = 2'b11;
        w_addr = 4'd1; d = 16'h0101; tick;
        w_addr = 4'd2; d = 16'h0202; tick;
        w_addr = 4'd3; d = 16'hBEEF; tick;
        we = 1'b0;
        re = 1'b1; r_addr = 4'd1; tick;
        chk("b2b_a_1", 32'(if_a.q), 32'h0101);
        r_addr = 4'd2; tick;
        chk("b2b_a_2", 32'(if_a.q), 32'h0202);
        chk("b2b_b_1", 32'(if_b.q), 32'h0101);
        r_addr = 4'd3; tick;
        re = 1'b0;
        chk("b2b_a_3", 32'(if_a.q), 32'hBEEF);
        chk("b2b_c_3", 32'(if_c.q), 32'hBEEF);
        chk("b2b_b_2", 32'(if_b.q), 32'h0202);
        chk("b2b_b_v2", 32'(if_b.q_valid), 1);
        tick;
        chk("b2b_b_3", 32'(if_b.q), 32'hBEEF);
        chk("b2b_a_v_end", 32'(if_a.q_valid), 0);

        // Read-during-write at addr 7
        we = 1'b1; be = 2'b11; w_addr = 4'd7; d = 16'h1111; tick;
        be = 2'b01; d = 16'h22FF; re = 1'b1; r_addr = 4'd7; tick;
        we = 1'b0; re = 1'b0;
        chk("rdw_a_old", 32'(if_a.q), 32'h1111);
        chk("rdw_c_new", 32'(if_c.q), 32'h11FF);
        tick;
        chk("rdw_b_new", 32'(if_b.q), 32'h11FF);
        // Write elsewhere while reading addr 7: no interaction
        we = 1'b1; be = 2'b11; w_addr = 4'd8; d = 16'h5A5A;
        re = 1'b1; r_addr = 4'd7; tick;
        we = 1'b0; re = 1'b0;
        chk("rdw_a_after", 32'(if_a.q), 32'h11FF);
        chk("rdw_c_after", 32'(if_c.q), 32'h11FF);
        tick;
        chk("rdw_b_after", 32'(if_b.q), 32'h11FF);
        re = 1'b1; r_addr = 4'd8; tick;
        re = 1'b0;
        chk("diff_a_8", 32'(if_a.q), 32'h5A5A);

        // Reset one cycle after a read flushes B's pipeline
        re = 1'b1; r_addr = 4'd5; tick;
        re = 1'b0; reset = 1'b1; tick;
        chk("flush_b_q", 32'(if_b.q), 0);
        chk("flush_b_v", 32'(if_b.q_valid), 0);
        chk("flush_a_q", 32'(if_a.q), 0);
        reset = 1'b0; tick;
        chk("flush_b_v2", 32'(if_b.q_valid), 0);
        chk("flush_b_busy", 32'(if_b.init_busy), 1);
        chk("flush_c_busy", 32'(if_c.init_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
